// File: rtl/pixel_layer_sequencer.sv
// Per-frame draw scheduler: walks enabled layers in ascending order, grants one
// layer at a time and forwards its opaque pixels to a registered VGA write port.
module pixel_layer_sequencer #(
   parameter int                     NUM_LAYERS = 9,
   parameter int                     X_W        = 8,
   parameter int                     Y_W        = 7,
   parameter int                     COLOUR_W   = 3,
   parameter bit                     TRANSP_EN  = 1'b1,
   parameter logic [COLOUR_W-1:0]    TRANSP_KEY = '0,
   parameter int                     TIMEOUT    = 20000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_start,
   input  logic [NUM_LAYERS-1:0]            layer_enable,
   input  logic [NUM_LAYERS*X_W-1:0]        layer_x,
   input  logic [NUM_LAYERS*Y_W-1:0]        layer_y,
   input  logic [NUM_LAYERS*COLOUR_W-1:0]   layer_colour,
   input  logic [NUM_LAYERS-1:0]            layer_valid,
   input  logic [NUM_LAYERS-1:0]            layer_done,
   output logic [NUM_LAYERS-1:0]            layer_go,
   output logic [NUM_LAYERS-1:0]            layer_ready,
   output logic [X_W-1:0]                   vga_x,
   output logic [Y_W-1:0]                   vga_y,
   output logic [COLOUR_W-1:0]              vga_colour,
   output logic                             vga_plot,
   output logic [$clog2(NUM_LAYERS)-1:0]    cur_layer,
   output logic                             busy,
   output logic                             frame_done,
   output logic [NUM_LAYERS-1:0]            timeout_err,
   output logic                             overrun
);

   localparam int CUR_W = $clog2(NUM_LAYERS);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DRAW, S_NEXT, S_FINISH} state_t;

   state_t                  r_state, w_state_nxt;
   logic [NUM_LAYERS-1:0]   r_en;
   logic [NUM_LAYERS-1:0]   r_timeout_err;
   logic [CUR_W-1:0]        r_cur;
   logic [CNT_W-1:0]        r_cnt;
   logic [X_W-1:0]          r_vga_x;
   logic [Y_W-1:0]          r_vga_y;
   logic [COLOUR_W-1:0]     r_vga_colour;
   logic                    r_vga_plot;

   logic [CUR_W-1:0]        w_first_idx, w_next_idx;
   logic                    w_first_found, w_next_found;
   logic [X_W-1:0]          w_pix_x;
   logic [Y_W-1:0]          w_pix_y;
   logic [COLOUR_W-1:0]     w_pix_c;
   logic                    w_accept, w_transp, w_done_cur, w_cnt_last;

   // Lowest enabled index: among fresh enables (frame accept) and above the current layer.
   always_comb begin
      w_first_found = 1'b0;
      w_first_idx   = '0;
      w_next_found  = 1'b0;
      w_next_idx    = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_enable[i]) begin
            w_first_found = 1'b1;
            w_first_idx   = CUR_W'(i);
         end
         if (r_en[i] && (i > int'(r_cur))) begin
            w_next_found = 1'b1;
            w_next_idx   = CUR_W'(i);
         end
      end
   end

   assign w_pix_x    = layer_x[int'(r_cur)*X_W +: X_W];
   assign w_pix_y    = layer_y[int'(r_cur)*Y_W +: Y_W];
   assign w_pix_c    = layer_colour[int'(r_cur)*COLOUR_W +: COLOUR_W];
   assign w_accept   = (r_state == S_DRAW) && layer_valid[r_cur];
   assign w_transp   = TRANSP_EN && (r_cur != '0) && (w_pix_c == TRANSP_KEY);
   assign w_done_cur = layer_done[r_cur];
   assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: every output and next-state is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      layer_go    = '0;
      layer_ready = '0;
      busy        = 1'b0;
      frame_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (frame_start) w_state_nxt = w_first_found ? S_START : S_FINISH;
         end
         S_START: begin
            busy            = 1'b1;
            layer_go[r_cur] = 1'b1;
            w_state_nxt     = S_DRAW;
         end
         S_DRAW: begin
            busy               = 1'b1;
            layer_ready[r_cur] = 1'b1;
            if (w_done_cur || w_cnt_last) w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            busy        = 1'b1;
            w_state_nxt = w_next_found ? S_START : S_FINISH;
         end
         S_FINISH: begin
            frame_done  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_en          <= '0;
         r_timeout_err <= '0;
         r_cur         <= '0;
         r_cnt         <= '0;
         r_vga_x       <= '0;
         r_vga_y       <= '0;
         r_vga_colour  <= '0;
         r_vga_plot    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_vga_plot <= w_accept && !w_transp;
         if (w_accept) begin
            r_vga_x      <= w_pix_x;
            r_vga_y      <= w_pix_y;
            r_vga_colour <= w_pix_c;
         end
         unique case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_en          <= layer_enable;
                  r_timeout_err <= '0;
                  r_cur         <= w_first_idx;
               end
            end
            S_START: r_cnt <= '0;
            S_DRAW: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (!w_done_cur && w_cnt_last) r_timeout_err[r_cur] <= 1'b1;
            end
            S_NEXT: begin
               if (w_next_found) r_cur <= w_next_idx;
            end
            default: ;
         endcase
      end
   end

   assign overrun     = frame_start && (r_state != S_IDLE);
   assign vga_x       = r_vga_x;
   assign vga_y       = r_vga_y;
   assign vga_colour  = r_vga_colour;
   assign vga_plot    = r_vga_plot;
   assign cur_layer   = r_cur;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pixel_layer_sequencer.sv
// Directed bench for pixel_layer_sequencer: behavioural layer responders, a pixel/go
// monitor, and hand-derived per-frame expectations.
module tb_pixel_layer_sequencer;

   localparam int N = 9;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           frame_start = 1'b0;
   logic [N-1:0]   layer_enable = '0;
   logic [N*8-1:0] layer_x = '0;
   logic [N*7-1:0] layer_y = '0;
   logic [N*3-1:0] layer_colour = '0;
   logic [N-1:0]   layer_valid = '0;
   logic [N-1:0]   layer_done = '0;
   logic [N-1:0]   layer_go, layer_ready, timeout_err;
   logic [7:0]     vga_x;
   logic [6:0]     vga_y;
   logic [2:0]     vga_colour;
   logic           vga_plot, busy, frame_done, overrun;
   logic [3:0]     cur_layer;

   pixel_layer_sequencer #(
      .NUM_LAYERS(N), .X_W(8), .Y_W(7), .COLOUR_W(3),
      .TRANSP_EN(1'b1), .TRANSP_KEY(3'b000), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .layer_enable(layer_enable),
      .layer_x(layer_x), .layer_y(layer_y), .layer_colour(layer_colour),
      .layer_valid(layer_valid), .layer_done(layer_done), .layer_go(layer_go),
      .layer_ready(layer_ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .cur_layer(cur_layer), .busy(busy), .frame_done(frame_done),
      .timeout_err(timeout_err), .overrun(overrun)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Layer stimulus model
   int  npix[N];
   bit  stall[N];
   int  pix_cnt[N];
   bit  tr_mode = 1'b0;

   function automatic logic [7:0] px(input int i, input int k);
      if (tr_mode && i == 3 && k == 0) return 8'd10;
      return 8'(i * 16 + k);
   endfunction

   function automatic logic [6:0] py(input int i, input int k);
      if (tr_mode && i == 3 && k == 0) return 7'd20;
      return 7'(i + k * 8);
   endfunction

   function automatic logic [2:0] pc(input int i, input int k);
      if (i == 0 && k == 0) return 3'b000;
      if (tr_mode && i == 3 && k == 0) return 3'b000;
      return 3'(((i + k) % 7) + 1);
   endfunction

   // Responder: a granted layer presents its next pixel, raising done with the last one.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         layer_valid = '0;
         layer_done  = '0;
         for (int i = 0; i < N; i++) begin
            if (layer_ready[i] && pix_cnt[i] < npix[i]) begin
               layer_x[i*8 +: 8]      = px(i, pix_cnt[i]);
               layer_y[i*7 +: 7]      = py(i, pix_cnt[i]);
               layer_colour[i*3 +: 3] = pc(i, pix_cnt[i]);
               layer_valid[i]         = 1'b1;
               if (pix_cnt[i] == npix[i] - 1 && !stall[i]) layer_done[i] = 1'b1;
               pix_cnt[i]++;
            end else if (layer_ready[i] && !stall[i]) begin
               layer_done[i] = 1'b1;
            end
         end
      end
   end

   // Monitor
   logic [17:0] obs_q[$];
   int          go_q[$];
   int          cur_q[$];
   logic [N-1:0] ready_seen;
   int          busy_cycles, done_cnt, ovr_cnt, r5_cycles;

   task automatic clear_mon();
      obs_q.delete();
      go_q.delete();
      cur_q.delete();
      ready_seen  = '0;
      busy_cycles = 0;
      done_cnt    = 0;
      ovr_cnt     = 0;
      r5_cycles   = 0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (vga_plot) obs_q.push_back({vga_x, vga_y, vga_colour});
            for (int i = 0; i < N; i++) begin
               if (layer_go[i]) begin
                  go_q.push_back(i);
                  cur_q.push_back(int'(cur_layer));
               end
            end
            ready_seen = ready_seen | layer_ready;
            if (layer_ready[5]) r5_cycles++;
            if (busy) busy_cycles++;
            if (frame_done) done_cnt++;
            if (overrun) ovr_cnt++;
         end
      end
   end

   task automatic pulse_start(input logic [N-1:0] en, input logic [N-1:0] en_after);
      for (int i = 0; i < N; i++) pix_cnt[i] = 0;
      clear_mon();
      layer_enable = en;
      @(posedge clk);
      #1;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start  = 1'b0;
      layer_enable = en_after;
   endtask

   task automatic run_frame(input string tag, input logic [N-1:0] en, input logic [N-1:0] en_after);
      pulse_start(en, en_after);
      for (int c = 0; c < 2000; c++) begin
         if (done_cnt != 0) break;
         @(posedge clk);
         #1;
      end
      check({tag, "_finished"}, 32'(done_cnt != 0), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag, input logic [N-1:0] en, input int exp_busy);
      logic [17:0] exp_q[$];
      int          idx[$];
      logic [2:0]  c;
      int          m;
      for (int i = 0; i < N; i++) begin
         if (en[i]) begin
            idx.push_back(i);
            for (int k = 0; k < npix[i]; k++) begin
               c = pc(i, k);
               if (!(i != 0 && c == 3'b000)) exp_q.push_back({px(i, k), py(i, k), c});
            end
         end
      end
      check({tag, "_nplot"}, obs_q.size(), exp_q.size());
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int j = 0; j < m; j++) check($sformatf("%s_pix%0d", tag, j), obs_q[j], exp_q[j]);
      check({tag, "_ngo"}, go_q.size(), idx.size());
      m = (go_q.size() < idx.size()) ? go_q.size() : idx.size();
      for (int j = 0; j < m; j++) begin
         check($sformatf("%s_go%0d", tag, j), go_q[j], idx[j]);
         check($sformatf("%s_cur%0d", tag, j), cur_q[j], idx[j]);
      end
      check({tag, "_ready"}, ready_seen, en);
      check({tag, "_ndone"}, done_cnt, 1);
      check({tag, "_busy"}, busy_cycles, exp_busy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit found;
      for (int i = 0; i < N; i++) begin
         npix[i]  = 4;
         stall[i] = 1'b0;
         pix_cnt[i] = 0;
      end
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_go", layer_go, 0);
      check("rst_ready", layer_ready, 0);
      check("rst_plot", vga_plot, 0);
      check("rst_done", frame_done, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_cur", cur_layer, 0);
      check("rst_ovr", overrun, 0);
      check("rst_vgax", vga_x, 0);
      @(negedge clk);
      reset = 1'b0;

      // All nine layers, four pixels each: 6 busy cycles per layer
      run_frame("all", 9'h1FF, 9'h1FF);
      check_frame("all", 9'h1FF, 54);
      check("all_terr", timeout_err, 0);
      check("all_plot_idle", vga_plot, 0);
      check("all_vgax_hold", vga_x, 8'd131);

      // Sparse enable; enables changed after acceptance must not matter
      run_frame("sparse", 9'h105, 9'h1FF);
      check_frame("sparse", 9'h105, 18);

      // Nothing enabled: straight to FINISH
      run_frame("none", 9'h000, 9'h000);
      check_frame("none", 9'h000, 0);

      // Transparency: layer 3 colour 000 dropped, layer 0 colour 000 plotted
      tr_mode = 1'b1;
      run_frame("transp", 9'h009, 9'h009);
      check_frame("transp", 9'h009, 12);
      tr_mode = 1'b0;

      // Layer 5 stalls: 16 DRAW cycles then skipped
      npix[5]  = 0;
      stall[5] = 1'b1;
      run_frame("tmo", 9'h070, 9'h070);
      check_frame("tmo", 9'h070, 30);
      check("tmo_draw_len", r5_cycles, 16);
      check("tmo_terr", timeout_err, 9'h020);
      npix[5]  = 4;
      stall[5] = 1'b0;

      // frame_start during layer 2 DRAW -> overrun, frame unaffected, sticky error cleared
      fork
         run_frame("ovr", 9'h00F, 9'h00F);
         begin
            for (int c = 0; c < 200; c++) begin
               @(posedge clk);
               #2;
               if (cur_layer == 4'd2 && layer_ready[2]) begin
                  frame_start = 1'b1;
                  @(posedge clk);
                  #2;
                  frame_start = 1'b0;
                  break;
               end
            end
         end
      join
      check_frame("ovr", 9'h00F, 24);
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_terr_clr", timeout_err, 0);

      // frame_start in the FINISH cycle -> overrun and ignored
      pulse_start(9'h001, 9'h001);
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (frame_done) begin
            frame_start = 1'b1;
            #1;
            check("fin_ovr", overrun, 1);
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            check("fin_ignored", busy, 0);
            found = 1'b1;
            break;
         end
      end
      check("fin_found", found, 1);
      repeat (3) @(posedge clk);
      #1;
      check("fin_no_restart", busy, 0);

      // Reset while layer 4 streams
      pulse_start(9'h1FF, 9'h1FF);
      found = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #3;
         if (cur_layer == 4'd4 && layer_valid[4] && vga_plot) begin
            reset = 1'b1;
            #1;
            check("mid_rst_plot", vga_plot, 0);
            check("mid_rst_ready", layer_ready, 0);
            check("mid_rst_busy", busy, 0);
            found = 1'b1;
            break;
         end
      end
      check("mid_rst_found", found, 1);
      repeat (2) @(posedge clk);
      check("mid_rst_no_done", done_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      run_frame("post_rst", 9'h1FF, 9'h1FF);
      check_frame("post_rst", 9'h1FF, 54);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
